// File: rtl/mul_sn_trunc_seq_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier.
//   - FSM state encodings (IDLE/BUSY/DONE)
//   - bw_sign: sign of partial-product bit (i,j)
//   - bw_const: correction constant for the inverted-bit form of the negative terms,
//     restricted to columns >= lo so that masked terms leave no residue
//   - params_legal: W/TRUNC legality, checked at elaboration by the top
package mul_sn_trunc_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 1 when the term a_i*b_j carries negative weight (exactly one index is the sign bit)
    function automatic logic bw_sign(input int i, input int j, input int w);
        return (i == w - 1) != (j == w - 1);
    endfunction

    // Each negative term -x*2^k is built as (~x)*2^k - 2^k. Columns W-1..2W-3 each hold
    // two such terms, so the constant is -sum(2^(k+1)) over the kept columns.
    // With lo=0 this reduces to the classic 2^W + 2^(2W-1) (mod 2^2W).
    function automatic logic [31:0] bw_const(input int w, input int lo);
        logic [31:0] c;
        c = '0;
        for (int k = w - 1; k <= 2 * w - 3; k++) begin
            if (k >= lo) c = c - (32'd1 << (k + 1));
        end
        return c;
    endfunction

    function automatic bit params_legal(input int w, input int trunc);
        return (w >= 2) && (w <= 16) && (trunc >= 0) && (trunc <= 2 * w - 1);
    endfunction

endpackage

// File: rtl/mul_sn_trunc_seq_if.sv
// Operand/result handshake bundle for mul_sn_trunc_seq.
//   in_valid/in_ready + a, b, approx : operand side
//   out_valid/out_ready + o, o_approx : result side
// slave modport is the multiplier's view, master the producer/consumer's view.
interface mul_sn_trunc_seq_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           approx;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] o;
    logic           o_approx;

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, o, o_approx
    );

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, o, o_approx
    );
endinterface

// File: rtl/mul_sn_trunc_seq_bw_pp_row.sv
// One Baugh-Wooley partial-product row, combinational.
//   i_b      : full multiplier operand
//   i_a_bit  : multiplicand bit selecting this row (a[i_row])
//   i_row    : row index, also the left shift of the row
//   i_approx : drop bits whose column is below TRUNC
//   o_row    : 2W-bit row, negative-weight bits inverted, masked bits forced to 0
module mul_sn_trunc_seq_bw_pp_row
    import mul_sn_trunc_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 3
) (
    input  logic [W-1:0]         i_b,
    input  logic                 i_a_bit,
    input  logic [$clog2(W)-1:0] i_row,
    input  logic                 i_approx,
    output logic [2*W-1:0]       o_row
);

    logic [W-1:0] w_bits;

    always_comb begin
        w_bits = '0;
        for (int j = 0; j < W; j++) begin
            // Masked bits stay 0 so they never reach the adder, even when inverted.
            if (!i_approx || (int'(i_row) + j) >= TRUNC)
                w_bits[j] = (i_a_bit & i_b[j]) ^ bw_sign(int'(i_row), j, W);
        end
        o_row = {{W{1'b0}}, w_bits} << i_row;
    end

endmodule

// File: rtl/mul_sn_trunc_seq.sv
// Sequential signed WxW multiplier with per-transaction exact/truncated mode.
// One Baugh-Wooley row is accumulated per cycle: accept -> W BUSY cycles -> DONE.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/a/b/approx in, out_valid/out_ready/o/o_approx out
module mul_sn_trunc_seq
    import mul_sn_trunc_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 3
) (
    input logic               clock,
    input logic               reset,
    mul_sn_trunc_seq_if.slave bus
);

    localparam int RW = $clog2(W);
    localparam int PW = 2 * W;
    localparam logic [PW-1:0] C_EXACT  = PW'(bw_const(W, 0));
    localparam logic [PW-1:0] C_APPROX = PW'(bw_const(W, TRUNC));

    generate
        if (!params_legal(W, TRUNC)) begin : g_illegal
            $error("mul_sn_trunc_seq: W must be 2..16 and TRUNC 0..2W-1");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_approx;
    logic [RW-1:0] r_row;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_o;
    logic          r_o_approx;

    logic [PW-1:0] w_row;
    logic [PW-1:0] w_corr;
    logic [PW-1:0] w_sum;
    logic          w_last;

    mul_sn_trunc_seq_bw_pp_row #(.W(W), .TRUNC(TRUNC)) u_row (
        .i_b      (r_b),
        .i_a_bit  (r_a[r_row]),
        .i_row    (r_row),
        .i_approx (r_approx),
        .o_row    (w_row)
    );

    // The correction constant rides along with row 0 only.
    assign w_corr = (r_row == '0) ? (r_approx ? C_APPROX : C_EXACT) : '0;
    assign w_sum  = r_acc + w_row + w_corr;
    assign w_last = (r_row == RW'(W - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_approx   <= 1'b0;
            r_row      <= '0;
            r_acc      <= '0;
            r_o        <= '0;
            r_o_approx <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_approx <= bus.approx;
                        r_acc    <= '0;
                        r_row    <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_sum;
                    r_row <= r_row + 1'b1;
                    // o only updates on entry to DONE and holds through IDLE.
                    if (w_last) begin
                        r_o        <= w_sum;
                        r_o_approx <= r_approx;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.o         = r_o;
    assign bus.o_approx  = r_o_approx;

endmodule

// File: doc/mul_sn_trunc_seq.md
Name: mul_sN_trunc_seq

Overview:
- Parametrised, sequential signed (two's-complement) WxW multiplier with a per-transaction exact/approximate mode.
- Approximate mode drops every Baugh-Wooley partial-product bit in columns below TRUNC, trading accuracy for activity.
- Accumulates one partial-product row per cycle behind valid/ready handshakes on both sides.
- Sits as the characterisation/datapath successor of the fixed 8x8 approximate multipliers, for error-vs-cost sweeps across widths.

Parameters:
- W, 8, operand width in bits (legal range 2..16); the result is 2W bits.
- TRUNC, 3, number of low result columns dropped in approx mode (legal range 0..2W-1); TRUNC=0 makes approx mode identical to exact.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept a new operand pair.
- a  in  W  signed multiplicand.
- b  in  W  signed multiplier.
- approx  in  1  0 = exact product, 1 = truncated product.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- o  out  2W  signed product, two's complement.
- o_approx  out  1  mode flag captured with this transaction.

Behaviour:
- Reset: synchronous, active-high, so it is sampled only on a clock edge.
  - Clears state to IDLE, in_ready=1, out_valid=0, o=0, o_approx=0, and zeroes the accumulator and operand registers.
  - Reset asserted mid-operation aborts the transaction; no result is ever presented for it.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture a, b, approx, clear the accumulator, set row=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle add partial-product row `row` (bits a[row]&b[j], j=0..W-1) into the accumulator, then row++. After the row W-1 add, go to DONE.
  - DONE: out_valid=1 and o/o_approx are registered and stable. On out_ready, go to IDLE. Inputs are ignored while in BUSY or DONE.
- Latency: with acceptance at edge k, out_valid rises after edge k+W. Throughput is one result per W+2 cycles when out_ready is held high.
- Back-to-back: in_ready is not asserted in DONE. A new operand pair is accepted in the cycle after the output handshake.
- Arithmetic, Baugh-Wooley weighting:
  - Bit (i,j) has weight s_ij·2^(i+j).
  - s_ij = -1 when exactly one of i, j equals W-1; otherwise s_ij = +1.
  - Exact mode: o = sum over all (i,j) of s_ij·a_i·b_j·2^(i+j), taken mod 2^2W. This equals the true signed product.
  - Approx mode: same sum restricted to i+j >= TRUNC. As a consequence, o[TRUNC-1:0] = 0.
  - Negative terms are realised with the inverted-bit plus constant-correction form. The correction constant is added once, at row 0.
- Accumulator is 2W bits, wrapping mod 2^2W. No saturation is needed because the exact range fits, and approx results stay within ±2^(2W-1).
- Masking is applied per bit at row generation. Masked bits must not toggle the adder; they are forced to 0 before the add.
- Mode is sampled only at acceptance. Changing `approx` during BUSY has no effect.
- out_valid and o change only on the edge that leaves DONE or enters DONE. o holds its value in IDLE until the next entry to DONE.

Decomposition:
- Shared package mul_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - function bw_sign(i,j,W);
  - function bw_const(W) returning the Baugh-Wooley correction constant;
  - parameter-legality checks (elaboration-time assertions on W and TRUNC).
- One combinational sub-module, bw_pp_row: inputs a, b_bit/row index, approx, TRUNC; output is the row shifted and sign-corrected to 2W bits with the mask applied.
- FSM and accumulator live in the top module.

Test Plan:
- W=8, exact, a=-128, b=-128 -> o=0x4000, latency 8 cycles after acceptance, o_approx=0.
- W=8, exact, a=127, b=-128 -> o=0xC080. Exhaustive exact sweep (65536 pairs) must match the signed reference model.
- W=8, TRUNC=3, approx, a=7, b=7 -> o=0x0020 (kept pairs (1,2),(2,1),(2,2)). a=1, b=1 -> o=0x0000. Exhaustive sweep must match the truncated-sum model, with o[2:0]=0 always.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> o and out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE on the next edge, and the next pair is accepted one cycle later.
- Reset mid-op: assert reset at BUSY row 4 -> next cycle IDLE, out_valid=0, o=0. A following transaction a=3, b=-5 -> o=0xFFF1.
- Parameter sweep: W=4 with TRUNC=0 and W=12 with TRUNC=5, random operands -> approx results must match the model. With TRUNC=0, approx results must equal exact.
